mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Single-port memory controller between the core's instruction-fetch (IF) and load/store (LS) requesters and the word-wide synchronous memory. Grants one requester at a time and sequences the memory's 1-cycle read latency. Turns sub-word stores into read-modify-write sequences, because the memory has no byte enables. Sits between the core and `memory`, driving its address, write data and `mem_rw` ports directly.

## Interface
- `ADDR_W`, 32, byte-address width on all address ports.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `i_if_req` in 1: fetch request, held until `o_if_rvalid`.
- `i_if_addr` in ADDR_W: fetch byte address; bits [1:0] ignored.
- `o_if_rvalid` out 1: one-cycle pulse, `o_if_rdata` valid.
- `o_if_rdata` out 32: fetched word.
- `i_ls_req` in 1: LS request, held with all LS inputs stable until `o_ls_done`.
- `i_ls_we` in 1: 1 = store, 0 = load.
- `i_ls_addr` in ADDR_W: LS byte address; bits [1:0] ignored.
- `i_ls_wdata` in 32: store data, already lane-aligned.
- `i_ls_wmask` in 4: byte-lane enables for stores.
- `o_ls_done` out 1: one-cycle completion pulse.
- `o_ls_rdata` out 32: load word, valid with `o_ls_done` when `i_ls_we` = 0.
- `o_mem_addr` out ADDR_W: word-aligned byte address (bits [1:0] = 0).
- `o_mem_wdata` out 32: write data.
- `o_mem_rw` out 1: 1 = write, 0 = read.
- `i_mem_rdata` in 32: memory read data, valid the cycle after the read is issued.

## Operation
- FSM states:
  - IDLE: arbitrate.
  - RD: read data returns.
  - MERGE: RMW write cycle.
  - ACK: write completion.
- IDLE:
  - If no request, `o_mem_rw` = 0 and `o_mem_addr` holds its last value.
  - On a grant, drive the granted address combinationally in the same cycle.
  - Transitions:
    - IF, or LS load -> RD, `o_mem_rw` = 0.
    - LS store, wmask = 4'hF -> ACK, `o_mem_rw` = 1, `o_mem_wdata` = `i_ls_wdata`.
    - LS store, wmask in 1..4'hE -> MERGE, read issued.
    - LS store, wmask = 0 -> ACK, no memory access (`o_mem_rw` stays 0).
- RD: pulse the owner's valid/done; rdata = `i_mem_rdata` (passed through combinationally); -> IDLE.
- MERGE:
  - `o_mem_wdata` = per lane, `wmask[i]` ? `wdata` byte i : `i_mem_rdata` byte i.
  - `o_mem_rw` = 1; -> ACK.
- ACK: pulse `o_ls_done`; -> IDLE.
- The owner is latched at grant. Address, we, wdata and wmask are used live, because requesters hold them stable.
- A requester whose request drops before its completion pulse violates protocol; behaviour is undefined.
- A new grant is possible only in IDLE, so requests back-to-back from the same requester are separated by one IDLE cycle.
- `o_mem_rw` is gated by `!rst`: no write commits on a reset edge.

## Timing
- Reset values:
  - state = IDLE.
  - `o_if_rvalid` = `o_ls_done` = `o_mem_rw` = 0.
  - `o_mem_addr` = 0, `o_mem_wdata` = 0; rdata outputs = 0.
  - Last-grant = IF.
- Latencies, with request accepted in cycle N:
  - Load/fetch: valid/done at N+1.
  - Full-word store or wmask = 0: done at N+1.
  - Partial store: write at N+1, done at N+2.
- Throughput: one access per 2 cycles (reads, full stores); one per 3 cycles (partial stores).
- Reset mid-operation:
  - Returns to IDLE the next edge; no completion pulse for the aborted access.
  - A MERGE interrupted by reset leaves memory unmodified.
- Simultaneous `i_if_req` and `i_ls_req` in IDLE: resolved per Configuration; the loser waits, and is never dropped.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin arbitration.
  - On a tie, grant the requester not granted last.
  - The last-grant bit updates on every grant.
- `MEM_ARB_RR_EN` undefined: fixed priority, LS over IF.
  - Fetch can starve under continuous LS traffic; this is acceptable because the core serialises fetch and LS.

## Structure
- Shared package `mem_arb_pkg`:
  - State enum (IDLE/RD/MERGE/ACK).
  - Owner encoding (OWN_IF/OWN_LS).
  - `WMASK_FULL` = 4'hF.
  - `WORD_ALIGN` mask.
- Sub-module `wmask_merge`: combinational 4-lane byte merge (old word, new word, mask -> merged word). Arbiter, FSM and grant logic stay in `mem_arbiter`.

## Test plan
- IF read 0x10 while memory[4] = 0xDEADBEEF -> `o_if_rvalid` at N+1, `o_if_rdata` = 0xDEADBEEF, `o_mem_rw` = 0 throughout.
- LS store 0x20, wdata 0x12345678, wmask F -> `o_mem_rw` = 1 at N only, done at N+1; a following load of 0x20 returns 0x12345678.
- Partial store with memory[8] = 0xAABBCCDD, wdata 0x00EE0000, wmask 4'b0100 -> write at N+1 of 0xAAEECCDD, done at N+2.
- IF and LS requesting together from reset:
  - Fixed priority: LS, then IF.
  - `MEM_ARB_RR_EN`: LS (last-grant = IF), then IF, then LS if both are still asserted.
- Store with wmask 0 -> done at N+1, memory unchanged, `o_mem_rw` never 1.
- `rst` asserted in the MERGE cycle -> no write, no done pulse, state IDLE, all outputs at reset values the next cycle.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared FSM states, owner encoding and masks for mem_arbiter.
package mem_arb_pkg;
   typedef enum logic [1:0] {S_IDLE, S_RD, S_MERGE, S_ACK} state_t;
   typedef enum logic {OWN_IF, OWN_LS} owner_t;
   localparam logic [3:0]  WMASK_FULL = 4'hF;
   localparam logic [63:0] WORD_ALIGN = ~64'h3;
endpackage

// File: rtl/mem_arbiter_wmask_merge.sv
// wmask_merge: per-lane byte merge of a new word over an old word.
module wmask_merge (
   input  logic [31:0] old_i,
   input  logic [31:0] new_i,
   input  logic [3:0]  mask_i,
   output logic [31:0] merged_o
);
   for (genvar i = 0; i < 4; i++) begin : g_lane
      assign merged_o[8*i +: 8] = mask_i[i] ? new_i[8*i +: 8] : old_i[8*i +: 8];
   end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: IF/LS single-port memory arbiter with read-modify-write for sub-word stores.
// Define MEM_ARB_RR_EN for round-robin ties; default is fixed priority, LS over IF.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_if_req,
   input  logic [ADDR_W-1:0] i_if_addr,
   output logic              o_if_rvalid,
   output logic [31:0]       o_if_rdata,
   input  logic              i_ls_req,
   input  logic              i_ls_we,
   input  logic [ADDR_W-1:0] i_ls_addr,
   input  logic [31:0]       i_ls_wdata,
   input  logic [3:0]        i_ls_wmask,
   output logic              o_ls_done,
   output logic [31:0]       o_ls_rdata,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [31:0]       o_mem_wdata,
   output logic              o_mem_rw,
   input  logic [31:0]       i_mem_rdata
);
   state_t            state_q, state_d;
   owner_t            owner_q, owner_d;
   logic [ADDR_W-1:0] addr_q, addr_d, if_addr_w, ls_addr_w;
   logic [31:0]       wdata_q, wdata_d, merged;
   logic              rw_d, idle, gnt_if, gnt_ls;

   assign idle      = state_q == S_IDLE;
   assign if_addr_w = i_if_addr & WORD_ALIGN[ADDR_W-1:0];
   assign ls_addr_w = i_ls_addr & WORD_ALIGN[ADDR_W-1:0];
   // owner_q doubles as the last-grant bit: it only changes on a grant and resets to IF
`ifdef MEM_ARB_RR_EN
   assign gnt_ls = idle && i_ls_req && (!i_if_req || owner_q == OWN_IF);
`else
   assign gnt_ls = idle && i_ls_req;
`endif
   assign gnt_if = idle && i_if_req && !gnt_ls;

   wmask_merge u_merge (
      .old_i   (i_mem_rdata),
      .new_i   (i_ls_wdata),
      .mask_i  (i_ls_wmask),
      .merged_o(merged)
   );

   always_comb begin
      state_d = S_IDLE;
      owner_d = owner_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rw_d    = 1'b0;
      if (gnt_if) begin
         state_d = S_RD;
         owner_d = OWN_IF;
         addr_d  = if_addr_w;
      end else if (gnt_ls) begin
         owner_d = OWN_LS;
         addr_d  = ls_addr_w;
         if (!i_ls_we) state_d = S_RD;
         else if (i_ls_wmask == WMASK_FULL) begin
            state_d = S_ACK;
            rw_d    = 1'b1;
            wdata_d = i_ls_wdata;
         end else state_d = (i_ls_wmask == 4'h0) ? S_ACK : S_MERGE;
      end else if (state_q == S_MERGE) begin
         state_d = S_ACK;
         addr_d  = ls_addr_w;
         wdata_d = merged;
         rw_d    = 1'b1;
      end
   end

   assign o_mem_addr  = addr_d;
   assign o_mem_wdata = wdata_d;
   assign o_mem_rw    = rw_d && !rst;
   assign o_if_rvalid = state_q == S_RD && owner_q == OWN_IF;
   assign o_ls_done   = (state_q == S_RD || state_q == S_ACK) && owner_q == OWN_LS;
   assign o_if_rdata  = o_if_rvalid ? i_mem_rdata : 32'h0;
   assign o_ls_rdata  = (state_q == S_RD && owner_q == OWN_LS) ? i_mem_rdata : 32'h0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         owner_q <= OWN_IF;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of mem_arbiter against a per-cycle expectation schedule.
module tb_mem_arbiter;
   logic        clk = 0, rst = 1;
   logic        i_if_req = 0, i_ls_req = 0, i_ls_we = 0;
   logic [31:0] i_if_addr = 0, i_ls_addr = 0, i_ls_wdata = 0;
   logic [3:0]  i_ls_wmask = 0;
   logic        o_if_rvalid, o_ls_done, o_mem_rw;
   logic [31:0] o_if_rdata, o_ls_rdata, o_mem_addr, o_mem_wdata, mem_rdata;

   mem_arbiter #(.ADDR_W(32)) dut (
      .clk(clk), .rst(rst),
      .i_if_req(i_if_req), .i_if_addr(i_if_addr), .o_if_rvalid(o_if_rvalid), .o_if_rdata(o_if_rdata),
      .i_ls_req(i_ls_req), .i_ls_we(i_ls_we), .i_ls_addr(i_ls_addr), .i_ls_wdata(i_ls_wdata),
      .i_ls_wmask(i_ls_wmask), .o_ls_done(o_ls_done), .o_ls_rdata(o_ls_rdata),
      .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .o_mem_rw(o_mem_rw), .i_mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // word-wide synchronous memory with a bench-side preload port
   logic [31:0] mem [64];
   logic        pl_en = 0;
   logic [5:0]  pl_idx = 0;
   logic [31:0] pl_val = 0;
   always @(posedge clk) begin
      if (pl_en) mem[pl_idx] <= pl_val;
      else if (o_mem_rw) mem[o_mem_addr[7:2]] <= o_mem_wdata;
      mem_rdata <= mem[o_mem_addr[7:2]];
   end

   // expectation schedule, indexed by cycle
   bit          e_rv[1024], e_dn[1024], e_ld[1024], e_rw[1024], e_ac[1024], e_z[1024];
   logic [31:0] e_d[1024], e_a[1024], e_wd[1024];
   logic [31:0] ref_mem [64];
   int          total = 0, bad = 0;
   bit          last_ls = 0, rec = 0;
   bit          ord_q[$];
   logic [31:0] cap_if = 0, cap_ls = 0, cap_wd = 0;

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s cycle %0d: got %h want %h", n, cyc, a, e);
      end
   endtask

   always @(negedge clk) begin
      if (cyc >= 2) begin
         chk("if_rvalid", o_if_rvalid, e_rv[cyc]);
         chk("ls_done", o_ls_done, e_dn[cyc]);
         chk("mem_rw", o_mem_rw, e_rw[cyc]);
         if (e_rv[cyc]) chk("if_rdata", o_if_rdata, e_d[cyc]);
         if (e_ld[cyc]) chk("ls_rdata", o_ls_rdata, e_d[cyc]);
         if (e_ac[cyc]) chk("mem_addr", o_mem_addr, e_a[cyc]);
         if (e_rw[cyc]) chk("mem_wdata", o_mem_wdata, e_wd[cyc]);
         if (e_z[cyc]) begin
            chk("rst_addr", o_mem_addr, 0);
            chk("rst_wdata", o_mem_wdata, 0);
            chk("rst_if_rdata", o_if_rdata, 0);
            chk("rst_ls_rdata", o_ls_rdata, 0);
         end
      end
      if (o_if_rvalid) cap_if = o_if_rdata;
      if (o_ls_done && !i_ls_we) cap_ls = o_ls_rdata;
      if (o_mem_rw) cap_wd = o_mem_wdata;
      if (rec && o_if_rvalid) ord_q.push_back(1'b0);
      if (rec && o_ls_done) ord_q.push_back(1'b1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic poke(input int idx, input logic [31:0] v);
      pl_en = 1; pl_idx = 6'(idx); pl_val = v; ref_mem[idx] = v;
      step();
      pl_en = 0;
   endtask

   task automatic do_reset();
      rst = 1;
      step();
      rst = 0;
      last_ls = 0;
      e_z[cyc] = 1;
      step();
   endtask

   task automatic do_if(input logic [31:0] a);
      int n = cyc;
      i_if_req = 1; i_if_addr = a;
      e_ac[n] = 1; e_a[n] = a & ~32'h3;
      e_rv[n+1] = 1; e_d[n+1] = ref_mem[a[7:2]];
      step(); step();
      i_if_req = 0;
   endtask

   task automatic do_ls(input bit we, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] m);
      int n = cyc;
      logic [31:0] nw;
      i_ls_req = 1; i_ls_we = we; i_ls_addr = a; i_ls_wdata = wd; i_ls_wmask = m;
      e_a[n] = a & ~32'h3;
      e_ac[n] = !we || m != 0;
      if (!we) begin
         e_dn[n+1] = 1; e_ld[n+1] = 1; e_d[n+1] = ref_mem[a[7:2]];
      end else if (m == 4'hF) begin
         e_rw[n] = 1; e_wd[n] = wd; ref_mem[a[7:2]] = wd; e_dn[n+1] = 1;
      end else if (m == 0) e_dn[n+1] = 1;
      else begin
         for (int b = 0; b < 4; b++) nw[8*b +: 8] = m[b] ? wd[8*b +: 8] : ref_mem[a[7:2]][8*b +: 8];
         ref_mem[a[7:2]] = nw;
         e_ac[n+1] = 1; e_a[n+1] = a & ~32'h3; e_rw[n+1] = 1; e_wd[n+1] = nw; e_dn[n+2] = 1;
         step();
      end
      step(); step();
      i_ls_req = 0;
   endtask

   // IF fetches 0x10 and LS loads 0x20, each repeating; grants follow the arbitration rule
   task automatic tie(input int nif, input int nls);
      int free_at = cyc;
      int guard = 0;
      bit own_ls = 0;
      i_if_addr = 32'h10; i_ls_addr = 32'h20; i_ls_we = 0;
      rec = 1;
      while ((nif > 0 || nls > 0 || cyc < free_at) && guard < 100) begin
         int c = cyc;
         bit g_ls;
         if (c >= free_at && (nif > 0 || nls > 0)) begin
`ifdef MEM_ARB_RR_EN
            g_ls = nls > 0 && (nif == 0 || !last_ls);
`else
            g_ls = nls > 0;
`endif
            own_ls = g_ls; last_ls = g_ls; free_at = c + 2;
            e_ac[c] = 1; e_a[c] = g_ls ? 32'h20 : 32'h10;
            if (g_ls) begin
               e_dn[c+1] = 1; e_ld[c+1] = 1; e_d[c+1] = ref_mem[8]; nls--;
            end else begin
               e_rv[c+1] = 1; e_d[c+1] = ref_mem[4]; nif--;
            end
         end
         i_if_req = nif > 0 || (c < free_at && !own_ls);
         i_ls_req = nls > 0 || (c < free_at && own_ls);
         step();
         guard++;
      end
      if (guard >= 100) chk("tie_timeout", guard, 0);
      i_if_req = 0; i_ls_req = 0; rec = 0;
   endtask

   initial begin
      logic [3:0] ord;
      step(); step();
      rst = 0;
      e_z[cyc] = 1;
      step();
      poke(4, 32'hDEADBEEF);
      poke(5, 32'h55667788);
      do_if(32'h10);
      chk("if_word", cap_if, 32'hDEADBEEF);
      do_ls(1, 32'h20, 32'h12345678, 4'hF);
      do_ls(0, 32'h20, 32'h0, 4'h0);
      chk("load_after_store", cap_ls, 32'h12345678);
      poke(8, 32'hAABBCCDD);
      do_ls(1, 32'h23, 32'h00EE0000, 4'b0100);
      chk("merge_wdata", cap_wd, 32'hAAEECCDD);
      chk("merge_mem", mem[8], 32'hAAEECCDD);
      do_ls(1, 32'h14, 32'hFFFFFFFF, 4'h0);
      chk("mask0_mem", mem[5], 32'h55667788);
      do_ls(0, 32'h13, 32'h0, 4'h0);
      chk("load_unaligned", cap_ls, 32'hDEADBEEF);
      poke(8, 32'hAABBCCDD);
      begin
         int n = cyc;
         i_ls_req = 1; i_ls_we = 1; i_ls_addr = 32'h20; i_ls_wdata = 32'h000000FF; i_ls_wmask = 4'b0001;
         e_ac[n] = 1; e_a[n] = 32'h20;
         step();
         rst = 1; i_ls_req = 0;
         step();
         rst = 0;
         e_z[cyc] = 1;
         step();
      end
      chk("rst_merge_mem", mem[8], 32'hAABBCCDD);
      do_ls(0, 32'h20, 32'h0, 4'h0);
      chk("rst_merge_load", cap_ls, 32'hAABBCCDD);
      do_reset();
      tie(2, 2);
      chk("tie_count", ord_q.size(), 4);
      ord = 0;
      foreach (ord_q[i]) ord = {ord[2:0], ord_q[i]};
`ifdef MEM_ARB_RR_EN
      chk("tie_order", ord, 4'b1010);
`else
      chk("tie_order", ord, 4'b1100);
`endif
      do_if(32'h10);
      step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
